instr_fetch_buffer: RTL and testbench

Instruction fetch stage with prefetch buffering that sits directly upstream of the single-cycle RV32I core. It generates sequential fetch addresses and fetches words from a variable-latency instruction memory over a req/ack handshake. Fetched {pc, instruction} pairs are buffered in a small FIFO and presented to the core over a valid/ready interface. A redirect input handles taken branches and jumps by flushing the buffer and restarting at a new PC, including safe abandonment of an in-flight memory request.

---
 rtl/instr_fetch_buffer_if.sv | 25 ++
 rtl/instr_fetch_buffer.sv | 132 +++++++++++++
 tb/tb_instr_fetch_buffer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_buffer_if.sv
// Bus bundle for instr_fetch_buffer.
//   mem_*  : req/ack fetch channel to the instruction memory
//   inst_* : valid/ready delivery channel to the core
// master : the fetch buffer side (drives mem_req/mem_addr and the inst_* payload)
// slave  : the environment side (memory + core)
interface instr_fetch_buffer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_pc, inst_data,
    input  mem_ack, mem_rdata, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_pc, inst_data,
    output mem_ack, mem_rdata, inst_ready
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch stage with prefetch FIFO in front of the RV32I core.
// Issues sequential word fetches over a req/ack handshake, buffers
// {pc, instruction} pairs in a DEPTH-entry circular FIFO and hands them to
// the core over valid/ready. A redirect flushes the buffer and restarts at
// redirect_pc; a request that is still unacked at that moment is completed
// and its data dropped before the new address is issued.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : mem_req/mem_addr/mem_ack/mem_rdata and
//                  inst_valid/inst_pc/inst_data/inst_ready (master side)
//   redirect     : flush and restart at redirect_pc (bits [1:0] ignored)
//   count        : number of occupied FIFO entries, 0..DEPTH
module instr_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instr_fetch_buffer_if.master     bus,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]    state, state_nx;
  logic [31:0]   addr_q, addr_nx;
  logic [31:0]   fpc, fpc_nx;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q, count_nx;
  logic          push, pop;
  logic [31:0]   rpc;

  assign rpc = redirect_pc & 32'hFFFF_FFFC;

  assign bus.mem_req    = (state != IDLE);
  assign bus.mem_addr   = addr_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst_pc    = pc_mem[rd_ptr];
  assign bus.inst_data  = data_mem[rd_ptr];
  assign count          = count_q;

  // Redirect suppresses both pop and push: the flush wins.
  assign pop      = bus.inst_valid && bus.inst_ready && !redirect;
  assign push     = (state == REQ) && bus.mem_ack && !redirect;
  assign count_nx = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    fpc_nx   = fpc;
    case (state)
      IDLE: begin
        if (redirect) begin
          state_nx = REQ;
          addr_nx  = rpc;
          fpc_nx   = rpc;
        end else if (count_nx < DEPTH_C) begin
          state_nx = REQ;
          addr_nx  = fpc;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          if (redirect) begin
            fpc_nx  = rpc;
            addr_nx = rpc;
          end else begin
            fpc_nx = fpc + 32'd4;
            // Only keep requesting when the next word is guaranteed a slot.
            if (count_nx < DEPTH_C) addr_nx = fpc + 32'd4;
            else                    state_nx = IDLE;
          end
        end else if (redirect) begin
          // Request already on the bus: keep it stable and drop its data.
          fpc_nx   = rpc;
          state_nx = DISCARD;
        end
      end
      DISCARD: begin
        if (redirect) fpc_nx = rpc;
        if (bus.mem_ack) begin
          state_nx = REQ;
          addr_nx  = redirect ? rpc : fpc;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= RESET_PC;
      fpc     <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[PW'(i)]   <= '0;
        data_mem[PW'(i)] <= '0;
      end
    end else begin
      state  <= state_nx;
      addr_q <= addr_nx;
      fpc    <= fpc_nx;
      if (redirect) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]   <= fpc;
          data_mem[wr_ptr] <= bus.mem_rdata;
          wr_ptr           <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count_q <= count_nx;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: random-latency memory model,
// scoreboard of expected {pc, data} deliveries and directed scenarios.
module tb_instr_fetch_buffer;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic [CW-1:0] count;

  instr_fetch_buffer_if bus ();

  instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .count       (count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   delivered = 0;
  ent_t exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  bit   stale = 1'b0;
  int   max_lat = 0;
  bit   hold = 1'b0;
  int   lat = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory: each request completes after 0..max_lat wait cycles.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n || !bus.mem_req) begin
        bus.mem_ack = 1'b0;
        lat = -1;
      end else if (hold) begin
        bus.mem_ack = 1'b0;
        lat = 0;
      end else begin
        if (bus.mem_ack) lat = -1;
        if (lat < 0) lat = int'($urandom_range(0, max_lat));
        if (lat == 0) bus.mem_ack = 1'b1;
        else begin
          bus.mem_ack = 1'b0;
          lat--;
        end
      end
      bus.mem_rdata = bus.mem_ack ? mem_word(bus.mem_addr) : $urandom;
    end
  end

  // Reference model: after reset or redirect to P the core must see P, P+4, ...
  // one entry per completed non-stale fetch. A redirect while a request is
  // outstanding and unacked makes that request's eventual ack stale.
  always begin : model
    @(negedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      model_pc = RESET_PC;
      stale = 1'b0;
    end else if (redirect) begin
      exp_q.delete();
      stale = bus.mem_req && !bus.mem_ack;
      model_pc = redirect_pc & 32'hFFFF_FFFC;
    end else if (bus.mem_req && bus.mem_ack) begin
      if (stale) stale = 1'b0;
      else begin
        chk("fetch_addr", bus.mem_addr, model_pc);
        exp_q.push_back(ent_t'{pc: model_pc, data: mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // Monitor: occupancy and every consumed instruction against the scoreboard.
  always begin : monitor
    ent_t e;
    @(negedge clk);
    if (rst_n) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("count_le_depth", 32'(count <= CW'(DEPTH)), 32'd1);
      chk("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
      if (bus.inst_valid && bus.inst_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop: got pc %h expected no entry", bus.inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", bus.inst_pc, e.pc);
          chk("inst_data", bus.inst_data, e.data);
          delivered++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    logic [31:0] a;
    bus.inst_ready = 1'b1;
    rst_n = 1'b0;
    step(3);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, RESET_PC);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("first_req", 32'(bus.mem_req), 32'd1);
    chk("first_addr", bus.mem_addr, RESET_PC);

    // Zero-wait streaming: one instruction per cycle in steady state.
    step(4);
    d0 = delivered;
    step(10);
    chk("throughput", 32'(delivered - d0), 32'd10);

    // Backpressure until full, then a single pop refills one slot.
    bus.inst_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_1000;
    step(1);
    redirect = 1'b0;
    step(10);
    chk("full_count", 32'(count), DEPTH);
    chk("full_mem_req", 32'(bus.mem_req), 32'd0);
    bus.inst_ready = 1'b1;
    step(1);
    bus.inst_ready = 1'b0;
    chk("refill_req", 32'(bus.mem_req), 32'd1);
    chk("refill_addr", bus.mem_addr, 32'h0000_1010);
    step(2);
    chk("refill_count", 32'(count), DEPTH);
    chk("refill_idle", 32'(bus.mem_req), 32'd0);
    bus.inst_ready = 1'b1;
    step(8);

    // Redirect on the same edge as an ack.
    redirect = 1'b1;
    redirect_pc = 32'h0000_2000;
    @(negedge clk);
    chk("coincident_setup", 32'(bus.mem_req && bus.mem_ack), 32'd1);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    chk("coinc_count", 32'(count), 32'd0);
    chk("coinc_valid", 32'(bus.inst_valid), 32'd0);
    chk("coinc_addr", bus.mem_addr, 32'h0000_2000);
    chk("coinc_req", 32'(bus.mem_req), 32'd1);
    step(6);

    // Redirect while a request waits: stale address held until its ack.
    hold = 1'b1;
    step(2);
    a = bus.mem_addr;
    chk("wait_req", 32'(bus.mem_req), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_3000;
    step(1);
    redirect = 1'b0;
    chk("stale_addr", bus.mem_addr, a);
    chk("stale_count", 32'(count), 32'd0);
    step(2);
    chk("stale_hold", bus.mem_addr, a);
    hold = 1'b0;
    step(1);
    chk("after_stale_addr", bus.mem_addr, 32'h0000_3000);
    step(6);

    // Second redirect during DISCARD wins.
    hold = 1'b1;
    step(2);
    a = bus.mem_addr;
    redirect = 1'b1;
    redirect_pc = 32'h0000_3000;
    step(1);
    redirect = 1'b0;
    step(1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_4002;
    step(1);
    redirect = 1'b0;
    chk("discard2_addr", bus.mem_addr, a);
    step(1);
    hold = 1'b0;
    step(1);
    chk("discard2_new_addr", bus.mem_addr, 32'h0000_4000);
    step(1);
    chk("discard2_valid", 32'(bus.inst_valid), 32'd1);
    chk("discard2_pc", bus.inst_pc, 32'h0000_4000);
    step(4);

    // Random latency, random backpressure, occasional redirects.
    max_lat = 5;
    d0 = delivered;
    n = 0;
    while ((delivered - d0) < 1000 && n < 20000) begin
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 63) == 0);
      redirect_pc = $urandom;
      step(1);
      n++;
    end
    redirect = 1'b0;
    chk("random_delivered", 32'((delivered - d0) >= 1000), 32'd1);

    // Asynchronous reset with three entries buffered and a request pending.
    max_lat = 0;
    bus.inst_ready = 1'b0;
    step(2);
    redirect = 1'b1;
    redirect_pc = 32'h0000_5000;
    step(1);
    redirect = 1'b0;
    n = 0;
    while (count != CW'(3) && n < 20) begin
      step(1);
      n++;
    end
    hold = 1'b1;
    chk("mid_setup_count", 32'(count), 32'd3);
    chk("mid_setup_req", 32'(bus.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_addr", bus.mem_addr, RESET_PC);
    chk("mid_rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("mid_rst_pc", bus.inst_pc, 32'd0);
    chk("mid_rst_data", bus.inst_data, 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    step(1);
    hold = 1'b0;
    rst_n = 1'b1;
    step(1);
    chk("restart_req", 32'(bus.mem_req), 32'd1);
    chk("restart_addr", bus.mem_addr, RESET_PC);
    bus.inst_ready = 1'b1;
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
